alu_mul_seq: RTL and testbench

Multi-cycle unsigned multiplier that acts as the initiator on the ALU interface: it owns op1/op2/opcode and consumes res and the flags, in the same role the testbench modport plays. It computes the low 32 bits of mcand × mplier by shift-and-add, issuing one ADD, LSL or LSR per cycle to the shared combinational ALU. It sits beside the ALU in the execute stage and serves as the multiply unit for MULT/MULTU-class instructions without adding a dedicated datapath multiplier.

---
 rtl/alu_mul_seq_if.sv | 40 ++++
 rtl/alu_mul_seq.sv | 127 ++++++++++++
 tb/tb_alu_mul_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_if.sv
// ALU opcode/type package and the initiator/ALU bus interface used by alu_mul_seq.
package alu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  opcode_t;

    localparam opcode_t ADD = 4'h0;
    localparam opcode_t SUB = 4'h1;
    localparam opcode_t AND = 4'h2;
    localparam opcode_t OR  = 4'h3;
    localparam opcode_t XOR = 4'h4;
    localparam opcode_t LSL = 4'h5;
    localparam opcode_t LSR = 4'h6;
    localparam opcode_t HLT = 4'hF;

endpackage

// Shared combinational ALU bus: the initiator drives the operation and
// operands, and the ALU returns the result and flags in the same cycle.
interface alu_mul_seq_if;

    alu_pkg::opcode_t opcode;
    alu_pkg::word_t   op1;
    alu_pkg::word_t   op2;
    alu_pkg::word_t   res;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;

    modport master (
        output opcode, op1, op2,
        input  res, flag_z, flag_n, flag_v
    );

    modport slave (
        input  opcode, op1, op2,
        output res, flag_z, flag_n, flag_v
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier (low 32 bits of mcand * mplier) that
// borrows the shared ALU for every add and shift instead of owning a multiplier.
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  word_t         mcand,
    input  word_t         mplier,
    output logic          busy,
    output logic          done,
    output word_t         product,
    alu_mul_seq_if.master alu
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t state;
    word_t  a;      // multiplicand, shifted left once per processed bit
    word_t  b;      // multiplier, shifted right once per processed bit
    word_t  acc;    // running partial product
    logic   bz;     // remaining multiplier is zero

    // Negative and overflow flags play no part in the algorithm.
    logic unused_flags;
    assign unused_flags = alu.flag_n ^ alu.flag_v;

    assign product = acc;

    // Control FSM: sequences CHECK -> [ADD] -> SHL -> SHR per multiplier bit and
    // stops once the ALU reports the shifted multiplier has become zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            bz    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a     <= mcand;
                        b     <= mplier;
                        acc   <= '0;
                        // Only local zero test; later ones come from the ALU flag.
                        bz    <= (mplier == '0);
                        busy  <= 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bz) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (b[0]) begin
                        state <= S_ADD;
                    end else begin
                        state <= S_SHL;
                    end
                end
                S_ADD: begin
                    acc   <= alu.res;
                    state <= S_SHL;
                end
                S_SHL: begin
                    a     <= alu.res;
                    state <= S_SHR;
                end
                S_SHR: begin
                    b     <= alu.res;
                    bz    <= alu.flag_z;
                    state <= S_CHECK;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ALU drive decode: idle states present a harmless ADD 0+0.
    always_comb begin
        alu.opcode = ADD;
        alu.op1    = '0;
        alu.op2    = '0;
        case (state)
            S_ADD: begin
                alu.opcode = ADD;
                alu.op1    = acc;
                alu.op2    = a;
            end
            S_SHL: begin
                alu.opcode = LSL;
                alu.op1    = a;
                alu.op2    = 32'd1;
            end
            S_SHR: begin
                alu.opcode = LSR;
                alu.op1    = b;
                alu.op2    = 32'd1;
            end
            default: begin
                alu.opcode = ADD;
                alu.op1    = '0;
                alu.op2    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: a behavioural ALU on the slave side,
// per-cycle logging of each multiply, and hand-computed expectations.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic  clk;
    logic  rst;
    logic  start;
    word_t mcand;
    word_t mplier;
    logic  busy;
    logic  done;
    word_t product;

    alu_mul_seq_if alu_bus ();

    alu_mul_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product),
        .alu     (alu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural zero-latency ALU.
    always_comb begin
        logic [32:0] sum;
        sum = {1'b0, alu_bus.op1} + {1'b0, alu_bus.op2};
        alu_bus.res    = '0;
        alu_bus.flag_v = 1'b0;
        case (alu_bus.opcode)
            ADD: begin
                alu_bus.res    = sum[31:0];
                alu_bus.flag_v = (alu_bus.op1[31] == alu_bus.op2[31]) &&
                                 (sum[31] != alu_bus.op1[31]);
            end
            LSL:     alu_bus.res = alu_bus.op1 << alu_bus.op2;
            LSR:     alu_bus.res = alu_bus.op1 >> alu_bus.op2;
            default: alu_bus.res = '0;
        endcase
        alu_bus.flag_z = (alu_bus.res == '0);
        alu_bus.flag_n = alu_bus.res[31];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    localparam int MAXC = 150;

    logic        busy_log [0:MAXC-1];
    logic        done_log [0:MAXC-1];
    word_t       prod_log [0:MAXC-1];
    word_t       op1_log  [0:MAXC-1];
    word_t       op2_log  [0:MAXC-1];
    int          done_cyc;
    int          last_cyc;
    int          n_ops;
    logic [31:0] sig;

    // Issue one multiply and log every cycle until the cycle after done.
    // now=1 raises start in the current mid-cycle; inj is the cycle where a
    // 9*9 request is presented while the unit should still be busy.
    task automatic run_op(input word_t x, input word_t y, input int inj, input bit now);
        if (!now) @(negedge clk);
        start  = 1'b1;
        mcand  = x;
        mplier = y;
        @(negedge clk);
        done_cyc = -1;
        last_cyc = -1;
        n_ops    = 0;
        sig      = '0;
        for (int c = 0; c < MAXC; c++) begin
            if (c > 0) @(negedge clk);
            busy_log[c] = busy;
            done_log[c] = done;
            prod_log[c] = product;
            op1_log[c]  = alu_bus.op1;
            op2_log[c]  = alu_bus.op2;
            last_cyc    = c;
            if (!(alu_bus.opcode == ADD && alu_bus.op1 == '0 && alu_bus.op2 == '0)) begin
                n_ops++;
                sig = {sig[27:0], alu_bus.opcode};
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (c == inj) begin
                start  = 1'b1;
                mcand  = 32'd9;
                mplier = 32'd9;
            end else begin
                start  = 1'b0;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) break;
        end
        $display("txn mcand=0x%08h mplier=0x%08h done_cycle=%0d product=0x%08h ops=%0d",
                 x, y, done_cyc, (done_cyc >= 0) ? prod_log[done_cyc] : 32'h0, n_ops);
    endtask

    // Latency, pulse width, busy window and result of the last run_op.
    task automatic check_run(input string tag, input int exp_done, input word_t exp_prod);
        logic busy_ok;
        int   pulses;
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        if (done_cyc >= 0 && done_cyc + 1 < MAXC) begin
            busy_ok = 1'b1;
            pulses  = 0;
            for (int c = 0; c <= done_cyc; c++) begin
                if (!busy_log[c]) busy_ok = 1'b0;
                if (done_log[c]) pulses++;
            end
            check({tag, "_product"}, prod_log[done_cyc], exp_prod);
            check({tag, "_busy_window"}, busy_ok, 1'b1);
            check({tag, "_busy_after"}, busy_log[done_cyc + 1], 1'b0);
            check({tag, "_done_width"}, pulses + done_log[done_cyc + 1], 1);
            check({tag, "_product_hold"}, prod_log[done_cyc + 1], exp_prod);
        end
    endtask

    initial begin
        int dones;
        rst    = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_product", product, 32'h0);
        check("rst_opcode", alu_bus.opcode, ADD);
        check("rst_op1", alu_bus.op1, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 3*5: k=3, p=2 -> done in cycle 12; op trace ADD,LSL,LSR,LSL,LSR,ADD,LSL,LSR.
        run_op(32'd3, 32'd5, -1, 1'b0);
        check_run("m3x5", 12, 32'd15);
        check("m3x5_n_ops", n_ops, 8);
        check("m3x5_op_sig", sig, 32'h05656056);
        check("m3x5_shl_op1", op1_log[2], 32'd3);
        check("m3x5_shl_op2", op2_log[2], 32'd1);
        check("m3x5_shr_op1", op1_log[6], 32'd2);
        check("m3x5_add2_op1", op1_log[8], 32'd3);
        check("m3x5_add2_op2", op2_log[8], 32'd12);

        // Zero multiplier: CHECK then DONE, no ALU work.
        run_op(32'h1234, 32'h0, -1, 1'b0);
        check_run("m_zero", 1, 32'h0);
        check("m_zero_n_ops", n_ops, 0);

        // All ones squared wraps to 1: k=32, p=32.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        check_run("m_ones", 129, 32'h1);

        // Top bit only: k=32, p=1.
        run_op(32'd7, 32'h8000_0000, -1, 1'b0);
        check_run("m_top", 98, 32'h8000_0000);

        // 2^16 * 2^16 wraps to zero: k=17, p=1.
        run_op(32'h0001_0000, 32'h0001_0000, -1, 1'b0);
        check_run("m_wrap0", 53, 32'h0);

        // Zero multiplicand with nonzero multiplier: k=2, p=2.
        run_op(32'h0, 32'd3, -1, 1'b0);
        check_run("m_zmcand", 9, 32'h0);

        // Start while busy (cycle 4) is ignored, then back-to-back 9*9 in the
        // first idle cycle: k=4, p=2 -> 15 cycles.
        run_op(32'd3, 32'd5, 4, 1'b0);
        check_run("m_ignore", 12, 32'd15);
        run_op(32'd9, 32'd9, -1, 1'b1);
        check_run("m_b2b", 15, 32'd81);

        // Start during DONE is not accepted.
        run_op(32'd3, 32'd5, 12, 1'b0);
        check_run("m_in_done", 12, 32'd15);

        // Asynchronous reset in cycle 5 of a 3*5 run.
        @(negedge clk);
        start  = 1'b1;
        mcand  = 32'd3;
        mplier = 32'd5;
        @(negedge clk);
        start  = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_product", product, 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_product", product, 32'h0);
        check("mid_rst_opcode", alu_bus.opcode, ADD);
        check("mid_rst_op1", alu_bus.op1, 32'h0);
        check("mid_rst_op2", alu_bus.op2, 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("post_rst_quiet", dones, 0);
        run_op(32'd3, 32'd5, -1, 1'b0);
        check_run("post_rst", 12, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
